// File: rtl/audio_pkg.sv
// Shared audio types and defaults for the source arbiter and its neighbours.
// Optional feature macro used by the arbiter: AUDIO_ARB_UNDERRUN_CNT_EN.
package audio_pkg;

  localparam int SAMPLE_W_DEF        = 24;
  localparam int UNDERRUN_CYCLES_DEF = 3000;

  // Left channel occupies the upper half of the packed stereo word.
  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/audio_source_arbiter_if.sv
// Source-side valid/ready bundle plus the ADAU audio_in/audio_in_valid/audio_full handshake.
interface audio_source_arbiter_if
  import audio_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF
);
  logic [NUM_SRC-1:0]            src_en;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*2*SAMPLE_W-1:0] src_sample;
  logic [2*SAMPLE_W-1:0]         out_sample;
  logic                          out_valid;
  logic                          sink_full;

  // Arbiter side
  modport master (
    input  src_en, src_valid, src_sample, sink_full,
    output src_ready, out_sample, out_valid
  );

  // Producers and the ADAU driver
  modport slave (
    output src_en, src_valid, src_sample, sink_full,
    input  src_ready, out_sample, out_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/audio_source_arbiter.sv
// Round-robin stereo sample arbiter in front of the ADAU driver, with silence on underrun.
// Define AUDIO_ARB_UNDERRUN_CNT_EN to add the saturating underrun_count / underrun_clr ports.
module audio_source_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int SAMPLE_W        = SAMPLE_W_DEF,
  parameter int UNDERRUN_CYCLES = UNDERRUN_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  audio_source_arbiter_if.master     aif,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       underrun
`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
  ,
  input  logic                       underrun_clr,
  output logic [15:0]                underrun_count
`endif
);

  localparam int SMP_W = 2 * SAMPLE_W;
  localparam int IW    = $clog2(NUM_SRC);
  localparam int CW    = (UNDERRUN_CYCLES > 1) ? $clog2(UNDERRUN_CYCLES) : 1;

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      rr_ptr, gnt_idx;
  logic [NUM_SRC-1:0] eligible, gnt, src_ready_c;
  logic               any_req;
  logic [CW-1:0]      wait_cnt;
  logic               do_xfer, do_under, do_wait, consume;
  logic [SMP_W-1:0]   src_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_arr[i] = aif.src_sample[i*SMP_W +: SMP_W];
  end

  assign eligible      = aif.src_en & aif.src_valid;
  assign aif.src_ready = src_ready_c;

  rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    src_ready_c = '0;
    do_xfer     = 1'b0;
    do_under    = 1'b0;
    do_wait     = 1'b0;
    consume     = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = ARB;
      ARB: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (any_req) begin
          src_ready_c = gnt;
          do_xfer     = 1'b1;
          state_d     = HOLD;
        end else if (wait_cnt == CW'(UNDERRUN_CYCLES - 1)) begin
          do_under = 1'b1;
          state_d  = HOLD;
        end else begin
          do_wait = 1'b1;
        end
      end
      HOLD: begin
        // Enable is only sampled on the way out, so a held sample always drains.
        if (!aif.sink_full) begin
          consume = 1'b1;
          state_d = enable ? ARB : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- output stage: single registered sample toward the codec driver ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aif.out_sample <= '0;
      aif.out_valid  <= 1'b0;
      grant_id       <= '0;
      underrun       <= 1'b0;
      rr_ptr         <= '0;
      wait_cnt       <= '0;
    end else begin
      underrun <= do_under;
      if (do_xfer) begin
        aif.out_sample <= src_arr[gnt_idx];
        aif.out_valid  <= 1'b1;
        grant_id       <= gnt_idx;
        rr_ptr         <= (gnt_idx == IW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        wait_cnt       <= '0;
      end else if (do_under) begin
        aif.out_sample <= '0;
        aif.out_valid  <= 1'b1;
        wait_cnt       <= '0;
      end else if (do_wait) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (consume) aif.out_valid <= 1'b0;
    end
  end

`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               underrun_count <= '0;
    else if (underrun_clr)                      underrun_count <= '0;
    else if (do_under && underrun_count != '1)  underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_audio_source_arbiter.sv
// Scoreboard bench for audio_source_arbiter: expected transfers queued at stimulus time.
module tb_audio_source_arbiter;

  localparam int NS  = 4;
  localparam int SW  = 24;
  localparam int UC  = 8;
  localparam int SMP = 2 * SW;

  typedef struct {
    logic [SMP-1:0] smp;
    logic [1:0]     gid;
    logic           und;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] grant_id;
  logic       underrun;
`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
  logic        underrun_clr = 1'b0;
  logic [15:0] underrun_count;
`endif

  audio_source_arbiter_if #(.NUM_SRC(NS), .SAMPLE_W(SW)) aif ();

  audio_source_arbiter #(.NUM_SRC(NS), .SAMPLE_W(SW), .UNDERRUN_CYCLES(UC)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .aif      (aif),
    .grant_id (grant_id),
    .underrun (underrun)
`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
    ,
    .underrun_clr   (underrun_clr),
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   obs_cnt = 0;
  int   cyc = 0;
  int   phase_id = 0;
  int   bad13 = 0;
  int   bad_onehot = 0;
  logic prev_ov = 1'b0;
  exp_t exp_q[$];
  int   rise_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SMP-1:0] smp(input int p, input int i);
    audio_pkg::stereo_t s;
    s.left  = 24'(32'h00A50000 + p * 16 + i);
    s.right = 24'(32'h005A0100 + p * 256 + i * 17);
    return s;
  endfunction

  task automatic set_src(input int p);
    for (int i = 0; i < NS; i++) aif.src_sample[i*SMP +: SMP] = smp(p, i);
  endtask

  task automatic push_exp(input int src, input int p);
    exp_t e;
    e.smp = smp(p, src);
    e.gid = 2'(src);
    e.und = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_sil(input int gid);
    exp_t e;
    e.smp = '0;
    e.gid = 2'(gid);
    e.und = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int tgt;
    int k;
    tgt = obs_cnt + n;
    k = 0;
    while (obs_cnt < tgt && k < budget) begin
      tick();
      k++;
    end
    check_val("xfer_timeout", 64'(obs_cnt >= tgt), 64'd1);
  endtask

  // Monitor: each rising out_valid is one new sample handed to the codec.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (aif.out_valid && !prev_ov) begin
      obs_cnt++;
      rise_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("out_sample", 64'(aif.out_sample), 64'(e.smp));
        check_val("grant_id", 64'(grant_id), 64'(e.gid));
        check_val("underrun", 64'(underrun), 64'(e.und));
      end
    end
    prev_ov = aif.out_valid;
    if (phase_id == 2 && (aif.src_ready[1] || aif.src_ready[3])) bad13++;
    if ($countones(aif.src_ready) > 1) bad_onehot++;
  end

  initial begin
    int bad_stab, bad_rdy, bad_und, bad_ov;
    aif.src_en     = '0;
    aif.src_valid  = '0;
    aif.src_sample = '0;
    aif.sink_full  = 1'b0;

    // Reset state
    tick(2);
    check_val("rst_out_valid", 64'(aif.out_valid), 64'd0);
    check_val("rst_out_sample", 64'(aif.out_sample), 64'd0);
    check_val("rst_grant_id", 64'(grant_id), 64'd0);
    check_val("rst_underrun", 64'(underrun), 64'd0);
    check_val("rst_src_ready", 64'(aif.src_ready), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // Full rotation with all sources enabled
    phase_id = 1;
    set_src(1);
    aif.src_en = 4'hF;
    aif.src_valid = 4'hF;
    push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1); push_exp(0, 1);
    enable = 1'b1;
    wait_xfers(5, 60);
    enable = 1'b0;
    tick(4);
    check_val("p1_drain", 64'(exp_q.size()), 64'd0);
    check_val("p1_idle_valid", 64'(aif.out_valid), 64'd0);

    // Masked sources: pointer resumes at 1, so 2,0,2,0
    phase_id = 2;
    set_src(2);
    aif.src_en = 4'b0101;
    push_exp(2, 2); push_exp(0, 2); push_exp(2, 2); push_exp(0, 2);
    enable = 1'b1;
    wait_xfers(4, 60);
    enable = 1'b0;
    tick(4);
    phase_id = 0;
    check_val("p2_ready_1_3", 64'(bad13), 64'd0);
    check_val("p2_drain", 64'(exp_q.size()), 64'd0);

    // Underrun: silence every UC arbitration cycles, grant_id kept at 0
    phase_id = 3;
    aif.src_valid = '0;
    rise_q.delete();
    push_sil(0); push_sil(0); push_sil(0);
    enable = 1'b1;
    wait_xfers(3, 100);
    if (rise_q.size() >= 3) begin
      check_val("und_gap1", 64'(rise_q[1] - rise_q[0]), 64'(UC + 1));
      check_val("und_gap2", 64'(rise_q[2] - rise_q[1]), 64'(UC + 1));
    end else begin
      check_val("und_rises", 64'(rise_q.size()), 64'd3);
    end
`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
    check_val("und_count", 64'(underrun_count), 64'd3);
`endif
    enable = 1'b0;
`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check_val("und_count_clr", 64'(underrun_count), 64'd0);
`endif
    tick(3);
    check_val("p3_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure for 100 cycles in HOLD, then release
    phase_id = 4;
    set_src(4);
    aif.src_valid = 4'hF;
    aif.src_en = 4'hF;
    aif.sink_full = 1'b1;
    push_exp(1, 4); push_exp(2, 4);
    enable = 1'b1;
    wait_xfers(1, 20);
    bad_stab = 0; bad_rdy = 0; bad_und = 0; bad_ov = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (aif.out_sample !== smp(4, 1)) bad_stab++;
      if (aif.src_ready !== '0) bad_rdy++;
      if (underrun !== 1'b0) bad_und++;
      if (aif.out_valid !== 1'b1) bad_ov++;
    end
    check_val("hold_stable", 64'(bad_stab), 64'd0);
    check_val("hold_ready", 64'(bad_rdy), 64'd0);
    check_val("hold_underrun", 64'(bad_und), 64'd0);
    check_val("hold_valid", 64'(bad_ov), 64'd0);
    aif.sink_full = 1'b0;
    tick();
    check_val("consume_1cyc", 64'(aif.out_valid), 64'd0);
    wait_xfers(1, 10);

    // Enable dropped in the first HOLD cycle: sample still drains, then IDLE
    enable = 1'b0;
    aif.sink_full = 1'b1;
    tick(5);
    check_val("dis_hold_valid", 64'(aif.out_valid), 64'd1);
    check_val("dis_hold_sample", 64'(aif.out_sample), 64'(smp(4, 2)));
    aif.sink_full = 1'b0;
    tick();
    check_val("dis_consumed", 64'(aif.out_valid), 64'd0);
    tick(3);
    check_val("idle_valid", 64'(aif.out_valid), 64'd0);
    check_val("idle_ready", 64'(aif.src_ready), 64'd0);
    check_val("idle_underrun", 64'(underrun), 64'd0);
    check_val("idle_grant_id", 64'(grant_id), 64'd2);
    check_val("p45_drain", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of HOLD
    phase_id = 6;
    set_src(6);
    aif.sink_full = 1'b1;
    push_exp(3, 6);
    enable = 1'b1;
    wait_xfers(1, 20);
    reset_n = 1'b0;
    #1;
    check_val("arst_valid", 64'(aif.out_valid), 64'd0);
    check_val("arst_grant_id", 64'(grant_id), 64'd0);
    check_val("arst_sample", 64'(aif.out_sample), 64'd0);
    tick(2);
    check_val("arst_ready", 64'(aif.src_ready), 64'd0);
    push_exp(0, 6); push_exp(1, 6);
    aif.sink_full = 1'b0;
    reset_n = 1'b1;
    wait_xfers(2, 20);
    enable = 1'b0;
    tick(4);
    check_val("p6_drain", 64'(exp_q.size()), 64'd0);
    check_val("onehot_ready", 64'(bad_onehot), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_source_arbiter.md
Name: audio_source_arbiter

Overview:
- Shares the single stereo audio path into the ADAU interface between up to NUM_SRC sample producers (tone generator, CPU sample FIFO, test patterns).
- Round-robin arbitration per stereo sample. Registered single-sample output stage drives the adau_interface audio_in / audio_in_valid / audio_full handshake.
- Inserts silence on underrun so the codec never starves. Sits between the sources and the ADAU driver in the SoC top.

Parameters:
- NUM_SRC, 4, number of requesters (2..8)
- SAMPLE_W, 24, bits per channel; a stereo sample is 2*SAMPLE_W, left channel in the upper half
- UNDERRUN_CYCLES, 3000, idle cycles without an eligible source before a zero sample is inserted (must be greater than 0)

Ports:
- clk  in  1  system clock (clk_soc domain)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global arbiter enable
- src_en  in  NUM_SRC  per-source enable mask
- src_valid  in  NUM_SRC  source i presents a sample
- src_ready  out  NUM_SRC  one-hot accept strobe
- src_sample  in  NUM_SRC*2*SAMPLE_W  packed samples, source i at slice [i*2*SAMPLE_W +: 2*SAMPLE_W]
- out_sample  out  2*SAMPLE_W  sample to ADAU audio_in
- out_valid  out  1  to ADAU audio_in_valid
- sink_full  in  1  from ADAU audio_full
- grant_id  out  clog2(NUM_SRC)  source of the current or last transfer
- underrun  out  1  one-cycle pulse when a silence sample is inserted

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE, out_sample 0, out_valid 0, grant_id 0, underrun 0, rr pointer 0, wait counter 0. src_ready is 0 whenever not in ARB.
- Eligibility: source i is eligible when src_en[i] & src_valid[i].
- Sources follow valid/ready rules: hold valid and data stable until ready. A transfer happens when src_valid[i] & src_ready[i].
- States:
  - IDLE: outputs quiet. If enable is high, go to ARB next cycle.
  - ARB: src_ready is driven combinationally, one-hot at the first eligible index at or after the rr pointer, wrapping.
    - On transfer: out_sample <= that source's slice, out_valid <= 1, grant_id <= i, rr pointer <= i+1 mod NUM_SRC, wait counter <= 0, go to HOLD.
    - No eligible source: wait counter increments. When it reaches UNDERRUN_CYCLES-1: out_sample <= 0, out_valid <= 1, underrun pulses for one cycle, counter <= 0, go to HOLD. rr pointer and grant_id are unchanged.
    - enable low in ARB: go to IDLE with no transfer.
  - HOLD: out_valid stays 1 and out_sample stays stable. The sample is consumed in any cycle where sink_full is 0.
    - On consume: out_valid <= 0, then ARB if enable is high, else IDLE.
    - sink_full high: stay in HOLD indefinitely.
- Latency: source transfer to out_valid is 1 cycle. Minimum spacing between transfers is 2 cycles (ARB, HOLD), which is far faster than the codec rate.
- Boundaries:
  - enable dropped during HOLD: the held sample still completes, then IDLE.
  - src_en or src_valid changes during HOLD do not affect the held sample.
  - Eligibility vanishing in ARB before a transfer: no grant and no error. The counter continues from its value.
  - Only one source eligible: it is granted back-to-back.
  - rr pointer wraps from NUM_SRC-1 to 0.
  - Reset mid-HOLD: the held sample is discarded, out_valid drops immediately.

Optional Feature:
- Macro: AUDIO_ARB_UNDERRUN_CNT_EN.
- Defined: adds output underrun_count [15:0]. It resets to 0, increments on each underrun pulse, saturates at 0xFFFF, and clears synchronously when input underrun_clr (1 bit) is high. Clear takes precedence over a simultaneous increment.
- Undefined: neither port exists. Behaviour is otherwise identical.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W default constant
  - stereo sample typedef (left/right struct, 2*SAMPLE_W packed)
  - arbiter state enum (IDLE, ARB, HOLD)
  - UNDERRUN_CYCLES default
- Sub-module rr_arbiter: purely combinational. Takes request vector and pointer, returns one-hot grant, encoded index and any_req. It is reused by future bus arbiters.
- The state machine, counters and output register stay in audio_source_arbiter.

Test Plan:
- Reset then enable=1, src_en=4'b1111, all valid, sink_full=0. Grants rotate 0,1,2,3,0. Each out_sample equals the granted slice, and out_valid pulses once per grant.
- src_en=4'b0101 with all valid. Grants alternate only 0,2. Sources 1 and 3 never see src_ready.
- No source valid, UNDERRUN_CYCLES=8. Every 8th cycle in ARB produces out_sample=0 with out_valid=1 and an underrun pulse; grant_id is unchanged. With the macro defined, underrun_count increments, then clears on underrun_clr.
- sink_full=1 for 100 cycles while in HOLD. out_sample is stable, all src_ready=0, no underrun. Drop sink_full: the sample is consumed in 1 cycle and the next grant is the rotated source.
- enable=0 asserted in the same cycle HOLD is entered. The sample completes when sink_full=0, then IDLE with all outputs quiet.
- reset_n pulsed low mid-HOLD. out_valid, grant_id and rr pointer go to 0 asynchronously. After release with enable=1, the first grant is source 0.
